// File: rtl/seq_frame_parser_if.sv
// rtl/seq_frame_parser_if.sv - byte-in / sequence-memory-out bundle for the frame parser
interface seq_frame_parser_if;
  logic        flag;
  logic [7:0]  rx_1;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start_seq;
  logic        stop_seq;
  logic        frame_ok;
  logic        frame_err;
  logic        busy;

  modport master (
    output flag, rx_1,
    input  wr_en, wr_addr, wr_data, start_seq, stop_seq, frame_ok, frame_err, busy
  );

  modport slave (
    input  flag, rx_1,
    output wr_en, wr_addr, wr_data, start_seq, stop_seq, frame_ok, frame_err, busy
  );
endinterface

// File: rtl/seq_frame_parser.sv
// rtl/seq_frame_parser.sv - 8-byte command frame parser driving a sequence memory
module seq_frame_parser #(
  parameter int TIMEOUT = 8000
) (
  input  logic              c_rx,
  input  logic              rst_n,
  seq_frame_parser_if.slave bus
);

  localparam int         CW    = $clog2(TIMEOUT) + 1;
  localparam logic [7:0] SYNC  = 8'hAA;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    addr_q, addr_d;
  logic [31:0]   frame_data_q, frame_data_d;
  logic          chk_ok_q, chk_ok_d;
  logic [7:0]    wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          start_seq_q, start_seq_d;
  logic          stop_seq_q, stop_seq_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic          timed_out;

  // Idle limit hit this cycle; a byte arriving in the same cycle takes priority
  assign timed_out = (cnt_q == LIMIT) && !bus.flag;

  // Next-state, frame capture, running checksum and result pulses
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    xor_d        = xor_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    frame_data_d = frame_data_q;
    chk_ok_d     = chk_ok_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    start_seq_d  = 1'b0;
    stop_seq_d   = 1'b0;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      S_IDLE, S_EXEC: begin
        // EXEC retires the previous frame while still listening for a new sync byte
        if (state_q == S_EXEC) begin
          if (chk_ok_q && cmd_q == 8'h01) begin
            wr_en_d    = 1'b1;
            frame_ok_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = frame_data_q;
          end else if (chk_ok_q && cmd_q == 8'h02) begin
            start_seq_d = 1'b1;
            frame_ok_d  = 1'b1;
          end else if (chk_ok_q && cmd_q == 8'h03) begin
            stop_seq_d = 1'b1;
            frame_ok_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        cnt_d = '0;
        if (bus.flag && bus.rx_1 == SYNC) begin
          state_d = S_CMD;
          xor_d   = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (bus.flag) begin
          cnt_d = '0;
          xor_d = xor_q ^ bus.rx_1;
          case (state_q)
            S_CMD: begin
              cmd_d   = bus.rx_1;
              state_d = S_ADDR;
            end
            S_ADDR: begin
              addr_d  = bus.rx_1;
              idx_d   = 2'd3;
              state_d = S_DATA;
            end
            S_DATA: begin
              // D3 arrives first, so shifting left lands it in bits 31:24
              frame_data_d = {frame_data_q[23:0], bus.rx_1};
              if (idx_q == 2'd0) begin
                state_d = S_CHK;
              end else begin
                idx_d = idx_q - 2'd1;
              end
            end
            default: begin
              chk_ok_d = (xor_q == bus.rx_1);
              xor_d    = xor_q;
              state_d  = S_EXEC;
            end
          endcase
        end else if (timed_out) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
          cnt_d       = '0;
          idx_d       = 2'd0;
          xor_d       = 8'h00;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge c_rx or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      xor_q        <= 8'h00;
      cmd_q        <= 8'h00;
      addr_q       <= 8'h00;
      frame_data_q <= 32'h0;
      chk_ok_q     <= 1'b0;
      wr_addr_q    <= 8'h00;
      wr_data_q    <= 32'h0;
      wr_en_q      <= 1'b0;
      start_seq_q  <= 1'b0;
      stop_seq_q   <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      xor_q        <= xor_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      frame_data_q <= frame_data_d;
      chk_ok_q     <= chk_ok_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      start_seq_q  <= start_seq_d;
      stop_seq_q   <= stop_seq_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.start_seq = start_seq_q;
  assign bus.stop_seq  = stop_seq_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: doc/seq_frame_parser.md
SEQ_FRAME_PARSER -- requirements
Module: seq_frame_parser

Interface
REQ-001 Parameter: TIMEOUT, default 8000, inter-byte idle limit in clock cycles while a frame is open.
REQ-002 Port: c_rx  input  1  system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: flag  input  1  one-cycle pulse, received byte valid.
REQ-005 Port: rx_1  input  8  received byte, sampled only when flag=1.
REQ-006 Port: wr_en  output  1  one-cycle pulse, write wr_data to sequence memory at wr_addr.
REQ-007 Port: wr_addr  output  8  sequence memory word address.
REQ-008 Port: wr_data  output  32  sequence memory word.
REQ-009 Port: start_seq  output  1  one-cycle pulse, start sequence playback.
REQ-010 Port: stop_seq  output  1  one-cycle pulse, stop sequence playback.
REQ-011 Port: frame_ok  output  1  one-cycle pulse, valid frame executed.
REQ-012 Port: frame_err  output  1  one-cycle pulse, frame rejected (checksum, command, or timeout).
REQ-013 Port: busy  output  1  high while a frame is open (any state except IDLE).

Function
REQ-014 Frame format, 8 bytes: 0xAA sync, CMD, ADDR, D3, D2, D1, D0 (D3 = wr_data[31:24]), CHK.
REQ-015 CHK SHALL equal the XOR of CMD, ADDR, D3, D2, D1, D0; the sync byte is excluded.
REQ-016 States: IDLE, CMD, ADDR, DATA (2-bit byte index 3 down to 0), CHK, EXEC.
REQ-017 IDLE: flag with rx_1=0xAA -> CMD; flag with any other value is ignored with no error and no state change.
REQ-018 CMD, ADDR, DATA: each flag captures rx_1 into the frame register and folds it into the running XOR; DATA -> CHK after the fourth data byte.
REQ-019 CHK: a flag -> EXEC, with the checksum result registered.
REQ-020 EXEC lasts exactly one cycle, then IDLE; all result pulses are asserted in the cycle after EXEC is entered, i.e. 2 cycles after the CHK flag.
REQ-021 CMD 0x01 with good CHK: wr_addr<=ADDR, wr_data<={D3..D0}, wr_en=1, frame_ok=1.
REQ-022 CMD 0x02 with good CHK: start_seq=1, frame_ok=1; ADDR and data are ignored.
REQ-023 CMD 0x03 with good CHK: stop_seq=1, frame_ok=1.
REQ-024 Bad CHK with any CMD, or good CHK with any other CMD: frame_err=1 only; wr_addr and wr_data unchanged.
REQ-025 wr_addr and wr_data SHALL hold their values between writes.
REQ-026 Timeout counter: cleared on every accepted flag and in IDLE; increments each cycle in CMD, ADDR, DATA and CHK.
REQ-027 When the counter reaches TIMEOUT-1 with no flag that cycle: frame_err pulse next cycle, return to IDLE, frame discarded.
REQ-028 Flag and timeout in the same cycle: the flag wins, the byte is accepted, and the counter is cleared.
REQ-029 A flag arriving during EXEC is treated as an IDLE-state byte (an 0xAA starts a new frame).
REQ-030 At most one of wr_en, start_seq, stop_seq is high in any cycle; frame_ok and frame_err are never high together.
REQ-031 No 0xAA re-sync mid-frame: an 0xAA inside a frame is treated as data.

Reset
REQ-032 rst_n low SHALL immediately force: state=IDLE; counter, byte index and XOR=0; wr_addr=0x00; wr_data=0x00000000; all pulse outputs and busy=0.
REQ-033 Reset mid-frame discards the partial frame, and no pulse is generated on release.
REQ-034 The first rising edge after rst_n deasserts SHALL process normally.

Verification
REQ-035 Bytes AA 01 05 12 34 56 78 0C -> wr_en and frame_ok for one cycle, wr_addr=0x05, wr_data=0x12345678, 2 cycles after the last flag.
REQ-036 AA 02 00 00 00 00 00 02 then AA 03 00 00 00 00 00 03 -> one start_seq+frame_ok pulse, then one stop_seq+frame_ok pulse; no wr_en.
REQ-037 AA 01 05 12 34 56 78 0D -> frame_err only; wr_addr and wr_data keep their prior values.
REQ-038 Bytes 55 13 before a valid write frame -> no error, and the frame executes as in REQ-035; busy rises on the AA flag.
REQ-039 AA 01 then silence, with TIMEOUT=50 -> frame_err 50 cycles after the 01 flag; a following valid frame executes correctly.
REQ-040 rst_n pulsed low after AA 01 05 -> outputs zeroed; the remaining bytes 12 34 56 78 0C produce no pulses; the next full frame succeeds.
